multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the 16-bit CPU.
- Sequences fetch, decode, execute, memory and writeback for every instruction.
- Drives the 2-bit alu_op into the ALU control decoder.
- Runs start/done handshakes with the memory port and the iterative multiplier.
- Sits between the instruction register (opcode source) and the datapath muxes, register file, memory and multiplier.

Parameters:
- MUL_TIMEOUT, 32: maximum cycles in MUL_WAIT before abort.
- TO_W, 6: width of the timeout counter; must satisfy 2**TO_W > MUL_TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  4  from IR. 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 BNE, 0110 MUL; all others illegal.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- mul_done  in  1  multiplier result valid (1-cycle pulse).
- alu_op  out  2  00 add (LW/SW/PC), 01 sub (BEQ/BNE), 10 R-format, 11 MUL.
- alu_src_a  out  1  0 PC, 1 regA.
- alu_src_b  out  2  00 regB, 01 const 2, 10 sign-ext imm, 11 imm<<1.
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target).
- pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write  out  1 each  datapath enables/selects.
- mul_start  out  1  1-cycle start pulse to multiplier.
- state_o  out  4  current state encoding (debug).
- illegal  out  1  registered 1-cycle pulse on illegal opcode.
- mul_timeout  out  1  registered 1-cycle pulse on multiplier abort.

Behaviour:
- reset high: at the edge, state <= FETCH, timeout counter <= 0, illegal and mul_timeout <= 0. Combinationally, while reset is high, every control output is forced to 0.
- Control outputs are Moore-decoded from state, except the gated enables in FETCH and BRANCH. Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, WBMEM 4, MEMWR 5, EXEC_R 6, WBR 7, BRANCH 8, MUL_WAIT 9.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready, then -> DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: LW/SW -> MEMADDR; R -> EXEC_R; BEQ/BNE -> BRANCH; MUL -> MUL_WAIT.
  - Illegal opcode -> FETCH, with illegal=1 on the following cycle.
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then -> WBMEM.
- WBMEM: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WBR.
- WBR: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = (BEQ & zero) | (BNE & ~zero).
  - -> FETCH.
- MUL_WAIT:
  - alu_op=11 and alu_src_a=1 throughout.
  - mul_start=1 only in the first cycle of MUL_WAIT; the counter clears on entry and increments each cycle.
  - mul_done -> WBR. mul_done arriving in the same cycle as mul_start is accepted.
  - If the counter reaches MUL_TIMEOUT-1 without mul_done: -> FETCH, mul_timeout=1 the next cycle, no reg_write.
  - mul_done arriving in the timeout cycle wins (go to WBR, no timeout pulse).
- Latency (cycles, zero wait states): R 4, LW 5, SW 4, BEQ/BNE 3, MUL 3+N where N is the cycles to mul_done.
- mem_ready/mul_done sampled outside their wait states are ignored.
- Reset mid-operation: abort immediately, no write enables asserted in the reset cycle, resume at FETCH.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_MUL);
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_R=10, ALUOP_MUL=11);
  - the state enum;
  - the alu_src_b encodings.
- One natural sub-module: mul_timeout_counter (load/clear, increment, terminal-count flag).

Test Plan:
- Reset, then opcode=0000 and mem_ready=1 every cycle → states 0,1,6,7,0. alu_op=10 in EXEC_R; reg_write=1 and reg_dst=1 only in WBR.
- LW with mem_ready low for 2 extra cycles in MEMRD → MEMRD lasts 3 cycles, mem_read=1 and i_or_d=1 throughout; WBMEM has mem_to_reg=1. Total 7 cycles.
- BEQ with zero=1 → pc_write=1 and pc_src=01 in BRANCH. BNE with zero=1 → pc_write=0. Both return to FETCH next cycle.
- MUL with mul_done on the 5th MUL_WAIT cycle → single mul_start pulse on cycle 1, alu_op=11, then WBR with reg_write=1.
- MUL with mul_done never asserted, MUL_TIMEOUT=32 → FETCH after 32 MUL_WAIT cycles, one-cycle mul_timeout pulse, reg_write never 1.
- Opcode 1111 → DECODE to FETCH plus a one-cycle illegal pulse. Reset asserted mid-MEMWR → mem_write=0 that cycle, state_o=0 next.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU op codes, control FSM states and the control-word bundle
package cpu_pkg;
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_BNE   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0110;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_MUL = 2'b11;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMRD    = 4'd3,
        WBMEM    = 4'd4,
        MEMWR    = 4'd5,
        EXEC_R   = 4'd6,
        WBR      = 4'd7,
        BRANCH   = 4'd8,
        MUL_WAIT = 4'd9
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       mul_start;
    } ctrl_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_MUL};
    endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/status inputs and datapath control outputs of the main FSM
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mul_done;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       mul_start;
    logic [3:0] state_o;
    logic       illegal;
    logic       mul_timeout;

    modport master (
        input  opcode, zero, mem_ready, mul_done,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, i_or_d,
               mem_read, mem_write, mem_to_reg, reg_dst, reg_write, mul_start,
               state_o, illegal, mul_timeout
    );
    modport slave (
        output opcode, zero, mem_ready, mul_done,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, i_or_d,
               mem_read, mem_write, mem_to_reg, reg_dst, reg_write, mul_start,
               state_o, illegal, mul_timeout
    );
endinterface

// File: rtl/multicycle_control_mul_timeout_counter.sv
// mul_timeout_counter: counts cycles spent waiting on the multiplier, flags the last allowed cycle
module mul_timeout_counter #(
    parameter int MUL_TIMEOUT = 32,
    parameter int TO_W        = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_zero,
    output logic o_tc
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) r_cnt <= '0;
        else                r_cnt <= r_cnt + 1'b1;
    end

    assign o_zero = (r_cnt == '0);
    assign o_tc   = (r_cnt == TO_W'(MUL_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the 16-bit CPU
// Control word is Moore-decoded from state; illegal and mul_timeout are registered pulses.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int MUL_TIMEOUT = 32,
    parameter int TO_W        = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t r_state;
    state_t w_next;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;
    logic   r_illegal;
    logic   r_mul_to;
    logic   w_cnt_zero;
    logic   w_tc;

    // The counter sits at zero outside MUL_WAIT, so it reads zero exactly on the entry cycle.
    mul_timeout_counter #(.MUL_TIMEOUT(MUL_TIMEOUT), .TO_W(TO_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (r_state != MUL_WAIT),
        .o_zero (w_cnt_zero),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:    w_next = bus.mem_ready ? DECODE : FETCH;
            DECODE:   w_next = (bus.opcode == OP_LW || bus.opcode == OP_SW)   ? MEMADDR :
                               (bus.opcode == OP_RTYPE)                       ? EXEC_R  :
                               (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) ? BRANCH  :
                               (bus.opcode == OP_MUL)                         ? MUL_WAIT : FETCH;
            MEMADDR:  w_next = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    w_next = bus.mem_ready ? WBMEM : MEMRD;
            MEMWR:    w_next = bus.mem_ready ? FETCH : MEMWR;
            EXEC_R:   w_next = WBR;
            MUL_WAIT: w_next = bus.mul_done ? WBR : w_tc ? FETCH : MUL_WAIT;
            default:  w_next = FETCH;
        endcase
    end

    always_comb begin
        w_dec = '0;
        case (r_state)
            FETCH: begin
                w_dec.mem_read  = 1'b1;
                w_dec.alu_src_b = SRCB_TWO;
                w_dec.ir_write  = bus.mem_ready;
                w_dec.pc_write  = bus.mem_ready;
            end
            DECODE:  w_dec.alu_src_b = SRCB_IMM_SH;
            MEMADDR: begin
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                w_dec.mem_read = 1'b1;
                w_dec.i_or_d   = 1'b1;
            end
            WBMEM: begin
                w_dec.reg_write  = 1'b1;
                w_dec.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                w_dec.mem_write = 1'b1;
                w_dec.i_or_d    = 1'b1;
            end
            EXEC_R: begin
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_op    = ALUOP_R;
            end
            WBR: begin
                w_dec.reg_write = 1'b1;
                w_dec.reg_dst   = 1'b1;
            end
            BRANCH: begin
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_op    = ALUOP_SUB;
                w_dec.pc_src    = PCSRC_ALUOUT;
                w_dec.pc_write  = (bus.opcode == OP_BEQ && bus.zero) || (bus.opcode == OP_BNE && !bus.zero);
            end
            MUL_WAIT: begin
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_op    = ALUOP_MUL;
                w_dec.mul_start = w_cnt_zero;
            end
            default: w_dec = '0;
        endcase
    end

    assign w_ctrl = reset ? '0 : w_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
            r_mul_to  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == DECODE) && !is_legal(bus.opcode);
            r_mul_to  <= (r_state == MUL_WAIT) && w_tc && !bus.mul_done;
        end
    end

    assign bus.alu_op      = w_ctrl.alu_op;
    assign bus.alu_src_a   = w_ctrl.alu_src_a;
    assign bus.alu_src_b   = w_ctrl.alu_src_b;
    assign bus.pc_src      = w_ctrl.pc_src;
    assign bus.pc_write    = w_ctrl.pc_write;
    assign bus.ir_write    = w_ctrl.ir_write;
    assign bus.i_or_d      = w_ctrl.i_or_d;
    assign bus.mem_read    = w_ctrl.mem_read;
    assign bus.mem_write   = w_ctrl.mem_write;
    assign bus.mem_to_reg  = w_ctrl.mem_to_reg;
    assign bus.reg_dst     = w_ctrl.reg_dst;
    assign bus.reg_write   = w_ctrl.reg_write;
    assign bus.mul_start   = w_ctrl.mul_start;
    assign bus.state_o     = r_state;
    assign bus.illegal     = r_illegal;
    assign bus.mul_timeout = r_mul_to;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences with hand-computed state/control expectations
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_mw;
    logic saw_rw;

    multicycle_control_if bus();

    multicycle_control #(.MUL_TIMEOUT(32), .TO_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go(input logic [3:0] op, input logic mr, input logic z, input logic md);
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.mul_done  = md;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.opcode = 4'd0; bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.mul_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_ir_write", bus.ir_write, 0);
        check("rst_state", bus.state_o, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_mul_to", bus.mul_timeout, 0);
        reset = 1'b0;
        #1;
        // R-type: 0,1,6,7,0
        check("r_fetch_mem_read", bus.mem_read, 1);
        check("r_fetch_ir_write", bus.ir_write, 1);
        check("r_fetch_pc_write", bus.pc_write, 1);
        check("r_fetch_srcb", bus.alu_src_b, 1);
        go(4'h0, 1, 0, 0);
        check("r_dec_state", bus.state_o, 1);
        check("r_dec_srcb", bus.alu_src_b, 3);
        go(4'h0, 1, 0, 0);
        check("r_exec_state", bus.state_o, 6);
        check("r_exec_aluop", bus.alu_op, 2);
        check("r_exec_reg_write", bus.reg_write, 0);
        go(4'h0, 1, 0, 0);
        check("r_wb_state", bus.state_o, 7);
        check("r_wb_reg_write", bus.reg_write, 1);
        check("r_wb_reg_dst", bus.reg_dst, 1);
        go(4'h0, 1, 0, 0);
        check("r_end_state", bus.state_o, 0);
        // LW with two wait cycles in MEMRD
        go(4'h1, 1, 0, 0);
        check("lw_dec", bus.state_o, 1);
        go(4'h1, 0, 0, 0);
        check("lw_memaddr", bus.state_o, 2);
        check("lw_memaddr_srcb", bus.alu_src_b, 2);
        check("lw_memaddr_srca", bus.alu_src_a, 1);
        for (int i = 0; i < 3; i++) begin
            go(4'h1, (i == 2), 0, 0);
            check("lw_memrd_state", bus.state_o, 3);
            check("lw_memrd_read", bus.mem_read, 1);
            check("lw_memrd_iord", bus.i_or_d, 1);
        end
        go(4'h1, 1, 0, 0);
        check("lw_wbmem_state", bus.state_o, 4);
        check("lw_wbmem_m2r", bus.mem_to_reg, 1);
        check("lw_wbmem_rw", bus.reg_write, 1);
        go(4'h1, 1, 0, 0);
        check("lw_end", bus.state_o, 0);
        // BEQ taken, BNE not taken then taken by flipping zero
        go(4'h3, 1, 1, 0);
        check("beq_dec", bus.state_o, 1);
        go(4'h3, 1, 1, 0);
        check("beq_state", bus.state_o, 8);
        check("beq_pc_write", bus.pc_write, 1);
        check("beq_pc_src", bus.pc_src, 1);
        check("beq_aluop", bus.alu_op, 1);
        go(4'h4, 1, 1, 0);
        check("beq_end", bus.state_o, 0);
        go(4'h4, 1, 1, 0);
        go(4'h4, 1, 1, 0);
        check("bne_state", bus.state_o, 8);
        check("bne_z1_pc_write", bus.pc_write, 0);
        bus.zero = 1'b0;
        #1;
        check("bne_z0_pc_write", bus.pc_write, 1);
        go(4'h4, 1, 0, 0);
        check("bne_end", bus.state_o, 0);
        // MUL, done on 5th MUL_WAIT cycle
        go(4'h6, 1, 0, 0);
        check("mul_dec", bus.state_o, 1);
        go(4'h6, 0, 0, 0);
        check("mul_w1_state", bus.state_o, 9);
        check("mul_w1_start", bus.mul_start, 1);
        check("mul_w1_aluop", bus.alu_op, 3);
        check("mul_w1_srca", bus.alu_src_a, 1);
        for (int i = 2; i <= 5; i++) begin
            go(4'h6, 0, 0, (i == 5));
            check("mul_wn_state", bus.state_o, 9);
            check("mul_wn_start", bus.mul_start, 0);
        end
        go(4'h6, 1, 0, 0);
        check("mul_wbr_state", bus.state_o, 7);
        check("mul_wbr_rw", bus.reg_write, 1);
        go(4'h6, 1, 0, 0);
        check("mul_end", bus.state_o, 0);
        // MUL timeout: 32 MUL_WAIT cycles, stray mem_ready ignored
        go(4'h6, 1, 0, 0);
        n_mw = 0;
        saw_rw = 1'b0;
        for (int i = 0; i < 32; i++) begin
            go(4'h6, 1, 0, 0);
            if (bus.state_o == 4'd9) n_mw++;
            saw_rw |= bus.reg_write;
        end
        check("to_wait_cycles", 8'(n_mw), 32);
        check("to_no_rw", saw_rw, 0);
        go(4'hF, 1, 0, 0);
        check("to_fetch", bus.state_o, 0);
        check("to_pulse", bus.mul_timeout, 1);
        check("to_no_rw_fetch", bus.reg_write, 0);
        // Illegal opcode
        go(4'hF, 1, 0, 0);
        check("ill_dec", bus.state_o, 1);
        check("to_pulse_end", bus.mul_timeout, 0);
        go(4'h6, 1, 0, 0);
        check("ill_fetch", bus.state_o, 0);
        check("ill_pulse", bus.illegal, 1);
        go(4'h6, 1, 0, 0);
        check("ill_pulse_end", bus.illegal, 0);
        // mul_done together with mul_start
        go(4'h6, 1, 0, 1);
        check("mul0_state", bus.state_o, 9);
        check("mul0_start", bus.mul_start, 1);
        go(4'h6, 1, 0, 0);
        check("mul0_wbr", bus.state_o, 7);
        go(4'h6, 1, 0, 0);
        go(4'h6, 1, 0, 0);
        // mul_done in the timeout cycle wins
        n_mw = 0;
        for (int i = 0; i < 32; i++) begin
            go(4'h6, 1, 0, (i == 31));
            if (bus.state_o == 4'd9) n_mw++;
        end
        check("tc_done_cycles", 8'(n_mw), 32);
        go(4'h2, 1, 0, 0);
        check("tc_done_wbr", bus.state_o, 7);
        check("tc_done_no_pulse", bus.mul_timeout, 0);
        go(4'h2, 1, 0, 0);
        check("tc_done_no_pulse2", bus.mul_timeout, 0);
        // SW, reset in the middle of MEMWR
        go(4'h2, 1, 0, 0);
        go(4'h2, 0, 0, 0);
        check("sw_memaddr", bus.state_o, 2);
        go(4'h2, 0, 0, 0);
        check("sw_memwr_state", bus.state_o, 5);
        check("sw_memwr_write", bus.mem_write, 1);
        check("sw_memwr_iord", bus.i_or_d, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("sw_rst_mem_write", bus.mem_write, 0);
        check("sw_rst_i_or_d", bus.i_or_d, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("sw_rst_state", bus.state_o, 0);
        check("sw_rst_fetch_read", bus.mem_read, 1);
        check("sw_rst_fetch_irw", bus.ir_write, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
